// File: rtl/nn_pkg.sv
// Shared types, default sizes and the output scaling function for the
// dense-layer MAC array.
package nn_pkg;

  localparam int N_NEURONS_DEF = 10;
  localparam int N_INPUTS_DEF  = 784;
  localparam int PIX_W         = 8;
  localparam int WGT_W         = 16;
  localparam int ACC_W         = 34;
  localparam int SHIFT         = 8;
  localparam int OUT_W         = 16;
  // Unsigned pixel widened by a zero sign bit, times a signed weight.
  localparam int PROD_W        = PIX_W + 1 + WGT_W;

  // Largest positive activation, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  // Scale the sum down, clamp negatives to zero and positives to OUT_W range.
  function automatic logic [OUT_W-1:0] sat_relu(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    logic [OUT_W-1:0]        res;
    sh = acc >>> SHIFT;
    if (sh[ACC_W-1]) begin
      res = {OUT_W{1'b0}};
    end else if (sh > SAT_MAX) begin
      res = SAT_MAX[OUT_W-1:0];
    end else begin
      res = sh[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_mac_array_if.sv
// Pixel/weight input stream and activation output stream of the MAC array.
interface neuron_mac_array_if #(
  parameter int N_NEURONS = nn_pkg::N_NEURONS_DEF
) ();
  import nn_pkg::*;

  logic                       pix_valid;
  logic                       pix_ready;
  logic [PIX_W-1:0]           pix_data;
  logic                       pix_last;
  logic [N_NEURONS*WGT_W-1:0] w_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [N_NEURONS*OUT_W-1:0] out_data;
  logic                       err_len;
  logic                       busy;

  modport master (
    output pix_valid, pix_data, pix_last, w_data, out_ready,
    input  pix_ready, out_valid, out_data, err_len, busy
  );

  modport slave (
    input  pix_valid, pix_data, pix_last, w_data, out_ready,
    output pix_ready, out_valid, out_data, err_len, busy
  );

endinterface

// File: rtl/neuron_mac.sv
// One neuron: registered pixel x weight product, running accumulator and a
// held, scaled/rectified/saturated activation.
module neuron_mac
  import nn_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    load,
  input  logic [PIX_W-1:0]        pix,
  input  logic signed [WGT_W-1:0] wgt,
  output logic [OUT_W-1:0]        act
);

  logic signed [PROD_W-1:0] pix_ext_s;
  logic signed [PROD_W-1:0] wgt_ext_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]         act_q, act_d;

  // Full-width signed product of the zero-extended pixel and the weight.
  always_comb begin
    pix_ext_s = PROD_W'($signed({1'b0, pix}));
    wgt_ext_s = PROD_W'(wgt);
    prod_s    = pix_ext_s * wgt_ext_s;
  end

  // Product is zero on idle cycles so the accumulator can add it every cycle.
  always_comb begin
    if (clr) begin
      prod_d = {PROD_W{1'b0}};
      acc_d  = {ACC_W{1'b0}};
    end else begin
      if (en) begin
        prod_d = prod_s;
      end else begin
        prod_d = {PROD_W{1'b0}};
      end
      acc_d = acc_q + ACC_W'(prod_q);
    end
    if (load) begin
      act_d = sat_relu(acc_q);
    end else begin
      act_d = act_q;
    end
  end

  // Product, accumulator and activation registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= {PROD_W{1'b0}};
      acc_q  <= {ACC_W{1'b0}};
      act_q  <= {OUT_W{1'b0}};
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      act_q  <= act_d;
    end
  end

  assign act = act_q;

endmodule

// File: rtl/neuron_mac_array.sv
// Dense-layer accumulator: frame FSM, beat counter and N_NEURONS parallel
// neuron_mac lanes sharing the incoming pixel.
module neuron_mac_array
  import nn_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int N_INPUTS  = N_INPUTS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  neuron_mac_array_if.slave  bus
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 drain_q, drain_d;
  logic                       pix_ready_q, pix_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic                       err_len_q, err_len_d;
  logic                       busy_q, busy_d;
  logic                       beat_s;
  logic                       last_cnt_s;
  logic                       mac_en_s;
  logic                       clr_s;
  logic                       load_s;
  logic [N_NEURONS*OUT_W-1:0] out_data_s;

  assign beat_s     = bus.pix_valid && pix_ready_q;
  assign last_cnt_s = (cnt_q == LAST_CNT);

  // Frame sequencing, pix_last consistency check and lane control strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    err_len_d = 1'b0;
    mac_en_s = 1'b0;
    clr_s    = 1'b0;
    load_s   = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat_s) begin
          if (bus.pix_last && !last_cnt_s) begin
            // Early pix_last: drop the whole frame.
            err_len_d = 1'b1;
            clr_s     = 1'b1;
            cnt_d     = {CNT_W{1'b0}};
            state_d   = IDLE;
          end else if (last_cnt_s) begin
            // Final beat; a missing pix_last is flagged but the frame completes.
            err_len_d = !bus.pix_last;
            mac_en_s  = 1'b1;
            cnt_d     = {CNT_W{1'b0}};
            drain_d   = 2'd0;
            state_d   = DRAIN;
          end else begin
            mac_en_s = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            state_d  = ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd2) begin
          load_s  = 1'b1;
          drain_d = 2'd0;
          state_d = OUTPUT;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          clr_s   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = OUTPUT;
        end
      end
      default: begin
        clr_s   = 1'b1;
        cnt_d   = {CNT_W{1'b0}};
        drain_d = 2'd0;
        state_d = IDLE;
      end
    endcase
    pix_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    out_valid_d = (state_d == OUTPUT);
    busy_d      = (state_d != IDLE);
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      drain_q     <= 2'd0;
      pix_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      pix_ready_q <= pix_ready_d;
      out_valid_q <= out_valid_d;
      err_len_q   <= err_len_d;
      busy_q      <= busy_d;
    end
  end

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    neuron_mac u_mac (
      .clk   (clk),
      .reset (reset),
      .en    (mac_en_s),
      .clr   (clr_s),
      .load  (load_s),
      .pix   (bus.pix_data),
      .wgt   (bus.w_data[k*WGT_W +: WGT_W]),
      .act   (out_data_s[k*OUT_W +: OUT_W])
    );
  end

  assign bus.pix_ready = pix_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_s;
  assign bus.err_len   = err_len_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac_array.sv
// Self-checking bench for neuron_mac_array: table of constant frames, random
// frames against a reference model, and hand-written corner sequences.
module tb_neuron_mac_array;
  import nn_pkg::*;

  localparam int NN = 10;
  localparam int NI = 784;
  localparam int VW = NN * 16;

  typedef struct {
    logic [7:0]         pix;
    logic signed [15:0] w0;
    logic signed [15:0] wr;
    int                 gap_pct;
    logic [15:0]        exp0;
    logic [15:0]        expr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  neuron_mac_array_if #(.N_NEURONS(NN)) bus ();

  neuron_mac_array #(.N_NEURONS(NN), .N_INPUTS(NI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            total = 0;
  int            bad = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] last_exp;
  bit            seen = 1'b0;
  vec_t          vecs[5];
  vec_t          ones;
  vec_t          rv;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] calc(input longint s);
    longint sh;
    sh = s >>> 8;
    if (sh < 0) return 16'd0;
    if (sh > 32767) return 16'h7FFF;
    return sh[15:0];
  endfunction

  // Drive stop_at beats; a full frame pushes its expected result and checks latency.
  task automatic send_frame(input vec_t v, input bit rnd, input int last_at, input int stop_at);
    longint             sum[NN];
    logic [7:0]         px;
    logic signed [15:0] w;
    logic [VW-1:0]      wv;
    logic [VW-1:0]      e;
    int                 t;
    for (int k = 0; k < NN; k++) sum[k] = 0;
    for (int i = 0; i < stop_at; i++) begin
      if (v.gap_pct > 0) begin
        for (int g = 0; g < 8 && int'($urandom_range(0, 99)) < v.gap_pct; g++) begin
          @(negedge clk);
          bus.pix_valid = 1'b0;
          @(posedge clk);
        end
      end
      px = rnd ? 8'($urandom_range(0, 255)) : v.pix;
      for (int k = 0; k < NN; k++) begin
        w = rnd ? 16'($urandom) : ((k == 0) ? v.w0 : v.wr);
        wv[k*16 +: 16] = w;
        sum[k] += longint'(px) * longint'(w);
      end
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.pix_data  = px;
      bus.w_data    = wv;
      bus.pix_last  = (i == last_at);
      t = 0;
      while (!bus.pix_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        total++;
        bad++;
        $display("FAIL pix_ready_timeout: got 0 for 50 cycles, expected 1");
        bus.pix_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    if (stop_at == NI) begin
      for (int k = 0; k < NN; k++) begin
        if (rnd) e[k*16 +: 16] = calc(sum[k]);
        else e[k*16 +: 16] = (k == 0) ? v.exp0 : v.expr;
      end
      exp_q.push_back(e);
      last_exp = e;
      #1;
      check("err_len_e0", VW'(bus.err_len), VW'(last_at != NI - 1));
      check("pix_ready_e0", VW'(bus.pix_ready), VW'(0));
      check("out_valid_e0", VW'(bus.out_valid), VW'(0));
      check("busy_e0", VW'(bus.busy), VW'(1));
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.pix_last  = 1'b0;
      @(posedge clk); #1;
      check("err_len_e1", VW'(bus.err_len), VW'(0));
      check("out_valid_e1", VW'(bus.out_valid), VW'(0));
      @(posedge clk); #1;
      check("out_valid_e2", VW'(bus.out_valid), VW'(0));
      @(posedge clk); #1;
      check("out_valid_e3", VW'(bus.out_valid), VW'(1));
    end else if (last_at == stop_at - 1) begin
      #1;
      check("err_len_early", VW'(bus.err_len), VW'(1));
      check("busy_after_err", VW'(bus.busy), VW'(0));
      check("pix_ready_after_err", VW'(bus.pix_ready), VW'(1));
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.pix_last  = 1'b0;
      @(posedge clk); #1;
      check("err_len_one_cycle", VW'(bus.err_len), VW'(0));
    end else begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.pix_last  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 30 && (exp_q.size() != 0 || bus.out_valid); t++) @(negedge clk);
    check("result_delivered", VW'(exp_q.size()), VW'(0));
  endtask

  // Scoreboard: compare each newly presented activation vector with the queue head.
  initial begin : monitor
    logic [VW-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got out_valid=1, expected no result");
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < NN; k++)
            check($sformatf("lane%0d", k), VW'(bus.out_data[k*16 +: 16]), VW'(e[k*16 +: 16]));
        end
      end else if (!bus.out_valid) begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    vecs[0] = '{pix: 8'd1,   w0: 16'sd1,     wr: 16'sd1,     gap_pct: 0,  exp0: 16'd3,     expr: 16'd3};
    vecs[1] = '{pix: 8'd10,  w0: -16'sd1,    wr: 16'sd2,     gap_pct: 0,  exp0: 16'd0,     expr: 16'd61};
    vecs[2] = '{pix: 8'd255, w0: 16'sd32767, wr: 16'sd32767, gap_pct: 0,  exp0: 16'd32767, expr: 16'd32767};
    vecs[3] = '{pix: 8'd3,   w0: -16'sd5,    wr: 16'sd100,   gap_pct: 30, exp0: 16'd0,     expr: 16'd918};
    vecs[4] = '{pix: 8'd200, w0: 16'sd7,     wr: -16'sd300,  gap_pct: 0,  exp0: 16'd4287,  expr: 16'd0};
    ones = vecs[0];
    rv   = '{pix: 8'd0, w0: 16'sd0, wr: 16'sd0, gap_pct: 30, exp0: 16'd0, expr: 16'd0};

    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'd0;
    bus.pix_last  = 1'b0;
    bus.w_data    = {VW{1'b0}};
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_ready", VW'(bus.pix_ready), VW'(0));
    check("rst_out_valid", VW'(bus.out_valid), VW'(0));
    check("rst_out_data", bus.out_data, VW'(0));
    check("rst_err_len", VW'(bus.err_len), VW'(0));
    check("rst_busy", VW'(bus.busy), VW'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("pix_ready_after_rst", VW'(bus.pix_ready), VW'(1));
    check("busy_after_rst", VW'(bus.busy), VW'(0));

    // Constant-data frames with hand-computed results.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i], 1'b0, NI - 1, NI);
      wait_drain();
    end

    // Random data with random input gaps against the reference model.
    for (int i = 0; i < 2; i++) begin
      send_frame(rv, 1'b1, NI - 1, NI);
      wait_drain();
    end

    // Output backpressure: result held, no new beats accepted.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_frame(rv, 1'b1, NI - 1, NI);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_data", bus.out_data, last_exp);
      check("bp_pix_ready", VW'(bus.pix_ready), VW'(0));
      check("bp_out_valid", VW'(bus.out_valid), VW'(1));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_released", VW'(bus.out_valid), VW'(0));
    check("bp_busy", VW'(bus.busy), VW'(0));
    wait_drain();

    // Early pix_last aborts the frame; the next clean frame is unaffected.
    send_frame(ones, 1'b0, 10, 11);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("err_no_output", VW'(bus.out_valid), VW'(0));
      check("err_no_repeat", VW'(bus.err_len), VW'(0));
    end
    send_frame(ones, 1'b0, NI - 1, NI);
    wait_drain();

    // Missing pix_last on the final beat: flagged, result still produced.
    send_frame(ones, 1'b0, -1, NI);
    wait_drain();

    // Reset mid-frame, then a full frame must match a fresh run.
    send_frame(vecs[1], 1'b0, -1, 400);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_pix_ready", VW'(bus.pix_ready), VW'(0));
    check("mid_rst_out_valid", VW'(bus.out_valid), VW'(0));
    check("mid_rst_out_data", bus.out_data, VW'(0));
    check("mid_rst_err_len", VW'(bus.err_len), VW'(0));
    check("mid_rst_busy", VW'(bus.busy), VW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("pix_ready_after_mid_rst", VW'(bus.pix_ready), VW'(1));
    send_frame(vecs[1], 1'b0, NI - 1, NI);
    wait_drain();

    repeat (5) @(negedge clk);
    check("queue_empty_end", VW'(exp_q.size()), VW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_mac_array.md
# neuron_mac_array

Dense-layer accumulator sitting directly downstream of the weight-fetch stage. It consumes one pixel per accepted beat together with the N_NEURONS weights read for that pixel index, and accumulates pixel×weight for every neuron over an N_INPUTS-beat frame. At frame end it scales, rectifies and saturates each sum, then presents all neuron activations on a valid/ready output.

## Interface
- N_NEURONS, 10, neurons computed in parallel
- N_INPUTS, 784, beats per frame (28×28 image)
- PIX_W, 8, unsigned pixel width
- WGT_W, 16, signed weight width
- ACC_W, 34, signed accumulator width; holds 784·255·2^15 without overflow
- SHIFT, 8, arithmetic right shift applied to the final sum
- OUT_W, 16, signed activation width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- pix_valid  in  1  pixel beat offered
- pix_ready  out  1  block can accept a beat
- pix_data  in  PIX_W  unsigned pixel
- pix_last  in  1  marks beat N_INPUTS-1 of the frame
- w_data  in  N_NEURONS·WGT_W  signed weights for this beat; neuron k in bits [k·WGT_W +: WGT_W]; aligned with pix_data in the same cycle
- out_valid  out  1  activations available
- out_ready  in  1  consumer accepts activations
- out_data  out  N_NEURONS·OUT_W  activations, same packing as w_data
- err_len  out  1  one-cycle pulse: pix_last position mismatch
- busy  out  1  frame in progress or result pending

## Operation
- States: IDLE, ACCUM, DRAIN, OUTPUT.
- IDLE: pix_ready=1, accumulators and beat counter zero. First accepted beat → ACCUM.
- ACCUM: pix_ready=1. Each accepted beat (pix_valid&&pix_ready) is one product per neuron: signed({1'b0,pix_data}) × w_data[k], stored in a product register; the following cycle adds the registered product, sign-extended to ACC_W, into acc[k]. The beat counter increments per accepted beat.
- Counter reaching N_INPUTS-1 on an accepted beat → DRAIN; pix_ready=0 from the next cycle.
- pix_last consistency check:
  - pix_last on a beat with counter ≠ N_INPUTS-1: pulse err_len, clear accumulators, product register and counter, → IDLE.
  - pix_last missing on beat N_INPUTS-1: pulse err_len, frame still completes.
- DRAIN: two cycles, letting the final product reach acc. Then out_data[k] = sat(relu(acc[k] >>> SHIFT)).
  - relu: negative → 0.
  - sat: value > 2^(OUT_W-1)-1 → 2^(OUT_W-1)-1.
  - Registered, → OUTPUT.
- OUTPUT: out_valid=1, pix_ready=0, out_data stable until out_valid&&out_ready. Then clear accumulators → IDLE.
- pix_valid gaps inside a frame are legal; nothing accumulates on non-accepted cycles.
- busy=1 in ACCUM, DRAIN and OUTPUT.

## Timing
- Reset values: pix_ready=0 while reset is low, 1 in the first cycle after release; out_valid=0, out_data=0, err_len=0, busy=0. State is IDLE; counter and accumulators are zero.
- Asserting reset mid-frame or in OUTPUT aborts immediately; no output is produced.
- Latency: the last beat is accepted at edge E0; out_valid is high from edge E3 (three cycles).
- Throughput: one beat per cycle. Minimum frame period is N_INPUTS+3 cycles plus output handshake cycles.
- Backpressure: out_ready low holds OUTPUT indefinitely with out_data constant. out_ready high on the first OUTPUT cycle gives the minimum period.
- err_len asserts in the cycle after the offending beat, for exactly one cycle.

## Structure
- Shared package nn_pkg holds: state enum (IDLE/ACCUM/DRAIN/OUTPUT), N_INPUTS/N_NEURONS defaults, and a sat_relu function (ACC_W in → OUT_W out, SHIFT applied).
- One sub-module: neuron_mac (single neuron: product register, accumulator, clear, sat_relu output), instantiated N_NEURONS times by generate.
- The FSM and beat counter live in neuron_mac_array only.

## Test plan
- All pixels 1, all weights 1, pix_last on beat 783 → every out_data lane = 784>>>8 = 3; out_valid at E3.
- Neuron 0 weights −1, others +2, pixels 10 → lane0 = 0 (relu); other lanes = 15680>>>8 = 61.
- Pixels 255, weights 32767 → sum 6,550,778,640 fits 34 bits; output saturates to 32767 in all lanes.
- Random pix_valid gaps (≈30% idle) with random data → outputs match a reference model. out_ready held low 5 cycles → out_data unchanged, pix_ready=0 throughout.
- pix_last on beat 10 → err_len single pulse, no out_valid. A following clean frame of all-1s gives 3.
- reset low at beat 400 → all outputs at reset values. The next full frame gives results identical to a fresh run.
